cache_miss_controller: RTL and testbench
========================================

CACHE_MISS_CONTROLLER -- requirements
Module: cache_miss_controller

Interface
REQ-001 Parameter TAG_WIDTH, default 26, address tag bits [31:6].
REQ-002 Parameter SET_WIDTH, default 2, set index bits [5:4].
REQ-003 Parameter OFFSET_WIDTH, default 4, byte offset bits [3:0]; WORDS = 2^(OFFSET_WIDTH-2) = 4 words per line; TAG_WIDTH+SET_WIDTH+OFFSET_WIDTH SHALL equal 32.
REQ-004 Port clk  input  1  clock; all state updates on rising edge.
REQ-005 Port reset  input  1  reset, asynchronous, active-high.
REQ-006 Ports cpu_req/cpu_we  input  1/1  CPU access valid / access is a store.
REQ-007 Ports cpu_addr/cpu_wdata  input  32/32  access address / store data.
REQ-008 Ports cpu_stall/cpu_rdata  output  1/32  hold the CPU pipeline / load data.
REQ-009 Ports hit/dirty/replace_tag/read_data  input  1/1/TAG_WIDTH/32  from the replacement block: lookup hit, victim dirty, victim tag, hit word.
REQ-010 Ports lru_en/array_wen  output  1/1  advance replacement order / write strobe into the replacement block wen (way selection is done there).
REQ-011 Ports fill_word/fill_data/fill_done  output  (OFFSET_WIDTH-2)/32/1  word index and data being refilled / pulse that writes tag, sets valid, clears dirty.
REQ-012 Ports wb_word/wb_data  output/input  (OFFSET_WIDTH-2)/32  victim word index read / victim word returned same cycle.
REQ-013 Ports mem_req/mem_we/mem_addr/mem_wdata  output  1/1/32/32  memory request, single-word per handshake.
REQ-014 Ports mem_ready/mem_rdata  input  1/32  word accepted (write) or valid (read).
REQ-015 Ports hit_count/miss_count  output  32/32  performance counters (REQ-036).

Function
REQ-016 FSM states SHALL be IDLE, WRITEBACK, REFILL, RESUME; 2-bit encoding; word counter width OFFSET_WIDTH-2.
REQ-017 IDLE, cpu_req=1, hit=1: cpu_stall=0, cpu_rdata=read_data, lru_en=1 combinationally; store additionally asserts array_wen=1 same cycle; zero-cycle hit latency.
REQ-018 IDLE, cpu_req=1, hit=0: cpu_stall=1 same cycle; capture cpu_addr, replace_tag, dirty; word counter cleared; next state WRITEBACK if dirty=1 else REFILL.
REQ-019 IDLE, cpu_req=0: all strobes 0, cpu_stall=0, state unchanged.
REQ-020 WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim_tag, set, cnt, 2'b00}, wb_word=cnt, mem_wdata=wb_data.
REQ-021 WRITEBACK, mem_ready=1: cnt increments; at cnt=WORDS-1 counter wraps to 0 and next state is REFILL.
REQ-022 REFILL: mem_req=1, mem_we=0, mem_addr={req_tag, set, cnt, 2'b00}.
REQ-023 REFILL, mem_ready=1: array_wen=1, fill_word=cnt, fill_data=mem_rdata same cycle; cnt increments; at cnt=WORDS-1 fill_done=1 same cycle and next state RESUME.
REQ-024 RESUME: one cycle, cpu_stall=1, no memory request; next state IDLE, where the replayed lookup hits.
REQ-025 cpu_stall SHALL be 1 in every state other than IDLE.
REQ-026 mem_ready with mem_req=0 SHALL be ignored; mem_req SHALL stay 1 until each word's mem_ready.
REQ-027 hit, cpu_req, cpu_addr changes outside IDLE SHALL be ignored; a started miss always completes.
REQ-028 Back-to-back misses: a miss in IDLE directly after RESUME SHALL start a new sequence without an extra idle cycle.
REQ-029 mem_addr/mem_we/mem_wdata SHALL be 0 whenever mem_req=0.

Reset
REQ-030 reset=1 SHALL asynchronously force state IDLE, counter 0, captured address/tag/dirty 0.
REQ-031 During and after reset: cpu_stall, mem_req, mem_we, array_wen, lru_en, fill_done SHALL be 0; mem_addr, mem_wdata, cpu_rdata, fill_data 0 unless driven per REQ-017.
REQ-032 Reset mid-WRITEBACK/REFILL SHALL drop mem_req in the same cycle; the partial line is not marked valid.
REQ-033 hit_count and miss_count SHALL reset to 0.

Configuration
REQ-034 Macro CACHE_PERF_CNT_EN selects performance counting.
REQ-035 Without CACHE_PERF_CNT_EN: hit_count and miss_count SHALL be constant 0; no counter flops.
REQ-036 With CACHE_PERF_CNT_EN: hit_count increments per REQ-017 cycle, miss_count per REQ-018 cycle; both wrap 0xFFFFFFFF->0.

Verification
REQ-037 Reset, then load 0x0000_0040, hit=1, read_data=0xDEADBEEF -> cpu_stall=0, cpu_rdata=0xDEADBEEF, lru_en=1, mem_req=0.
REQ-038 Clean miss load 0x0000_1234, dirty=0, mem_ready every cycle -> 4 reads at 0x1230,0x1234,0x1238,0x123C, fill_done on the 4th, RESUME, IDLE; stall 6 cycles total.
REQ-039 Dirty miss, replace_tag=0x5, set=1 -> 4 writes at 0x150..0x15C carrying wb_data, then 4 refill reads; mem_we 1 then 0.
REQ-040 Refill with mem_ready low 3 cycles per word -> mem_addr held stable, array_wen only on ready cycles, 16-cycle refill.
REQ-041 reset pulsed on 2nd refill word -> mem_req=0 immediately, state IDLE, no fill_done.
REQ-042 CACHE_PERF_CNT_EN defined, 3 hits + 2 misses -> hit_count=3, miss_count=2; undefined -> both 0.

Source files
------------

// File: rtl/cache_miss_controller.sv
// Cache miss controller: zero-cycle hits, write-back of a dirty victim, then line refill, one word per memory handshake.
// Optional performance counters are built when CACHE_PERF_CNT_EN is defined.
module cache_miss_controller #(
  parameter int TAG_WIDTH    = 26,
  parameter int SET_WIDTH    = 2,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  output logic                    cpu_stall,
  output logic [31:0]             cpu_rdata,
  input  logic                    hit,
  input  logic                    dirty,
  input  logic [TAG_WIDTH-1:0]    replace_tag,
  input  logic [31:0]             read_data,
  output logic                    lru_en,
  output logic                    array_wen,
  output logic [OFFSET_WIDTH-3:0] fill_word,
  output logic [31:0]             fill_data,
  output logic                    fill_done,
  output logic [OFFSET_WIDTH-3:0] wb_word,
  input  logic [31:0]             wb_data,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic                    mem_ready,
  input  logic [31:0]             mem_rdata,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);

  localparam int CW    = OFFSET_WIDTH - 2;
  localparam int WORDS = 1 << CW;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    RESUME    = 2'd3
  } state_t;

  state_t                 state, next_state;
  logic [CW-1:0]          cnt;
  logic [TAG_WIDTH-1:0]   req_tag, victim_tag;
  logic [SET_WIDTH-1:0]   req_set;
  logic                   victim_dirty;
  logic                   lookup_hit, lookup_miss, word_last, mem_xfer;

  assign lookup_hit  = (state == IDLE) && cpu_req && hit;
  assign lookup_miss = (state == IDLE) && cpu_req && !hit;
  assign word_last   = (cnt == CW'(WORDS - 1));
  assign mem_xfer    = ((state == WRITEBACK) || (state == REFILL)) && mem_ready;

  // Offset byte bits and the captured dirty flag are kept for visibility only.
  logic unused_sink;
  assign unused_sink = ^{cpu_addr[1:0], victim_dirty};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (lookup_miss) next_state = dirty ? WRITEBACK : REFILL;
      WRITEBACK: if (mem_ready && word_last) next_state = REFILL;
      REFILL:    if (mem_ready && word_last) next_state = RESUME;
      RESUME:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Counter wraps naturally, so WRITEBACK hands REFILL a counter already at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      req_tag      <= '0;
      req_set      <= '0;
      victim_tag   <= '0;
      victim_dirty <= 1'b0;
    end else if (lookup_miss) begin
      cnt          <= '0;
      req_tag      <= cpu_addr[31 -: TAG_WIDTH];
      req_set      <= cpu_addr[OFFSET_WIDTH +: SET_WIDTH];
      victim_tag   <= replace_tag;
      victim_dirty <= dirty;
    end else if (mem_xfer) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    lru_en    = 1'b0;
    array_wen = 1'b0;
    fill_word = '0;
    fill_data = '0;
    fill_done = 1'b0;
    wb_word   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (cpu_req && hit) begin
            cpu_rdata = read_data;
            lru_en    = 1'b1;
            if (cpu_we) begin
              array_wen = 1'b1;
              fill_word = cpu_addr[OFFSET_WIDTH-1:2];
              fill_data = cpu_wdata;
            end
          end else if (cpu_req) begin
            cpu_stall = 1'b1;
          end
        end
        WRITEBACK: begin
          cpu_stall = 1'b1;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {victim_tag, req_set, cnt, 2'b00};
          wb_word   = cnt;
          mem_wdata = wb_data;
        end
        REFILL: begin
          cpu_stall = 1'b1;
          mem_req   = 1'b1;
          mem_addr  = {req_tag, req_set, cnt, 2'b00};
          if (mem_ready) begin
            array_wen = 1'b1;
            fill_word = cnt;
            fill_data = mem_rdata;
            fill_done = word_last;
          end
        end
        default: cpu_stall = 1'b1;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (lookup_hit)  hit_count  <= hit_count + 32'd1;
      if (lookup_miss) miss_count <= miss_count + 32'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_miss_controller.sv
// Directed bench for cache_miss_controller; checks hits, clean/dirty misses, stretched handshakes and mid-miss reset.
module tb_cache_miss_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        hit, dirty;
  logic [25:0] replace_tag;
  logic [31:0] read_data;
  logic        lru_en, array_wen, fill_done;
  logic [1:0]  fill_word, wb_word;
  logic [31:0] fill_data, wb_data;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] hit_count, miss_count;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int exp_hits   = 0;
  int exp_misses = 0;
  int stalls;

  always #5 clk = ~clk;

  cache_miss_controller dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .hit(hit), .dirty(dirty), .replace_tag(replace_tag), .read_data(read_data),
    .lru_en(lru_en), .array_wen(array_wen),
    .fill_word(fill_word), .fill_data(fill_data), .fill_done(fill_done),
    .wb_word(wb_word), .wb_data(wb_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_step();
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0; hit = 1'b0; mem_ready = 1'b1;
    #1;
    check("idle_stall", {31'd0, cpu_stall}, 32'd0);
    check("idle_mem_req", {31'd0, mem_req}, 32'd0);
    check("idle_lru", {31'd0, lru_en}, 32'd0);
    check("idle_mem_addr", mem_addr, 32'd0);
  endtask

  task automatic hit_step(input logic [31:0] addr, input logic we, input logic [31:0] rd, input logic [31:0] wd);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    hit = 1'b1; read_data = rd; mem_ready = 1'b1;
    #1;
    exp_hits++;
    check("hit_stall", {31'd0, cpu_stall}, 32'd0);
    check("hit_rdata", cpu_rdata, rd);
    check("hit_lru", {31'd0, lru_en}, 32'd1);
    check("hit_mem_req", {31'd0, mem_req}, 32'd0);
    check("hit_wen", {31'd0, array_wen}, {31'd0, we});
    if (we) begin
      check("store_word", {30'd0, fill_word}, {30'd0, addr[3:2]});
      check("store_data", fill_data, wd);
    end
  endtask

  // Full miss: request cycle, optional write-back, refill, resume; each word waits 'gap' cycles for ready.
  task automatic run_miss(input logic [31:0] addr, input logic d, input logic [25:0] vtag,
                          input int gap, output int stall_cycles);
    logic [31:0] exp_a;
    logic        rdy;
    stall_cycles = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr; hit = 1'b0;
    dirty = d; replace_tag = vtag; mem_ready = 1'b0;
    #1;
    exp_misses++;
    check("miss_stall", {31'd0, cpu_stall}, 32'd1);
    check("miss_mem_req", {31'd0, mem_req}, 32'd0);
    stall_cycles += cpu_stall;
    if (d) begin
      for (int w = 0; w < 4; w++) begin
        for (int g = 0; g <= gap; g++) begin
          @(negedge clk);
          rdy = (g == gap);
          cpu_addr = 32'hFFFF_FFF0; hit = 1'b1; dirty = 1'b0; replace_tag = 26'h3FF_FFFF;
          mem_ready = rdy; wb_data = 32'hB0B0_0000 + w;
          #1;
          exp_a = {vtag, addr[5:4], 4'b0000} + (w << 2);
          check("wb_req", {31'd0, mem_req}, 32'd1);
          check("wb_we", {31'd0, mem_we}, 32'd1);
          check("wb_addr", mem_addr, exp_a);
          check("wb_word", {30'd0, wb_word}, w);
          check("wb_wdata", mem_wdata, 32'hB0B0_0000 + w);
          stall_cycles += cpu_stall;
        end
      end
    end
    for (int w = 0; w < 4; w++) begin
      for (int g = 0; g <= gap; g++) begin
        @(negedge clk);
        rdy = (g == gap);
        cpu_addr = 32'hFFFF_FFF0; hit = 1'b1;
        mem_ready = rdy; mem_rdata = 32'hF111_0000 + w;
        #1;
        exp_a = {addr[31:4], 4'b0000} + (w << 2);
        check("rf_req", {31'd0, mem_req}, 32'd1);
        check("rf_we", {31'd0, mem_we}, 32'd0);
        check("rf_addr", mem_addr, exp_a);
        check("rf_wen", {31'd0, array_wen}, {31'd0, rdy});
        check("rf_done", {31'd0, fill_done}, {31'd0, rdy && (w == 3)});
        if (rdy) begin
          check("rf_word", {30'd0, fill_word}, w);
          check("rf_data", fill_data, 32'hF111_0000 + w);
        end
        stall_cycles += cpu_stall;
      end
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("resume_stall", {31'd0, cpu_stall}, 32'd1);
    check("resume_mem_req", {31'd0, mem_req}, 32'd0);
    check("resume_mem_addr", mem_addr, 32'd0);
    check("resume_wen", {31'd0, array_wen}, 32'd0);
    stall_cycles += cpu_stall;
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    hit = 1'b0; dirty = 1'b0; replace_tag = '0; read_data = '0;
    wb_data = '0; mem_ready = 1'b0; mem_rdata = '0;
    #12;
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_step();

    hit_step(32'h0000_0040, 1'b0, 32'hDEAD_BEEF, 32'd0);
    hit_step(32'h0000_0048, 1'b1, 32'h0000_0000, 32'h1111_2222);
    idle_step();

    run_miss(32'h0000_1234, 1'b0, 26'h0, 0, stalls);
    check("clean_stall_cycles", stalls, 32'd6);
    hit_step(32'h0000_1234, 1'b0, 32'hF111_0001, 32'd0);

    run_miss(32'h0000_2010, 1'b1, 26'h5, 0, stalls);
    check("dirty_stall_cycles", stalls, 32'd10);
    // Back-to-back: next miss starts right after RESUME.
    run_miss(32'h0000_3020, 1'b0, 26'h0, 3, stalls);
    check("slow_stall_cycles", stalls, 32'd18);
    idle_step();
`ifdef CACHE_PERF_CNT_EN
    check("pre_rst_hit_count", hit_count, exp_hits);
    check("pre_rst_miss_count", miss_count, exp_misses);
`else
    check("pre_rst_hit_count", hit_count, 32'd0);
    check("pre_rst_miss_count", miss_count, 32'd0);
`endif

    // Reset while the second refill word is outstanding.
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h0000_4000; hit = 1'b0; dirty = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h1;
    #1;
    check("prst_rf_addr0", mem_addr, 32'h0000_4000);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("prst_rf_addr1", mem_addr, 32'h0000_4004);
    reset = 1'b1;
    #1;
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_stall", {31'd0, cpu_stall}, 32'd0);
    check("midrst_fill_done", {31'd0, fill_done}, 32'd0);
    check("midrst_hit_count", hit_count, 32'd0);
    check("midrst_miss_count", miss_count, 32'd0);
    exp_hits = 0; exp_misses = 0;
    @(negedge clk);
    reset = 1'b0; cpu_req = 1'b0;
    idle_step();

    // Counter reset must restart the line at word 0.
    run_miss(32'h0000_5550, 1'b0, 26'h0, 0, stalls);
    hit_step(32'h0000_5550, 1'b0, 32'h0BAD_CAFE, 32'd0);
    run_miss(32'h0000_6660, 1'b1, 26'h2A, 1, stalls);
    check("dirty_gap_stall_cycles", stalls, 32'd18);
    hit_step(32'h0000_6660, 1'b0, 32'h1234_5678, 32'd0);
    hit_step(32'h0000_666C, 1'b1, 32'h0, 32'hCAFE_F00D);
    idle_step();
`ifdef CACHE_PERF_CNT_EN
    check("hit_count", hit_count, 32'd3);
    check("miss_count", miss_count, 32'd2);
`else
    check("hit_count", hit_count, 32'd0);
    check("miss_count", miss_count, 32'd0);
`endif
    check("bench_hits", exp_hits, 32'd3);
    check("bench_misses", exp_misses, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
